uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  8-bit UART transmitter: serialises a byte as start, 8 data bits LSB-first, optional parity, then stop bit(s) on one output line.
//  Transmit-side counterpart of the GPIO UART receive path; drives a GPIO pin on the same CLOCK_50 domain.
//  Uses a valid/ready byte handshake so a host FSM or FIFO can stream frames back-to-back.
// PARAMETERS
//  CLKS_PER_BIT  868  CLOCK_50 cycles per bit (868 = 57600 baud at 50 MHz); legal range >= 2
//  STOP_BITS     1    number of stop bits; legal values 1 or 2
//  PARITY_ODD    0    parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd
// PORTS
//  CLOCK_50   in   1  system clock; all logic on posedge
//  s_reset_n  in   1  synchronous reset, active-low
//  tx_data    in   8  byte to send; sampled only on the accept cycle
//  tx_valid   in   1  host has a byte for transmission
//  tx_ready   out  1  block can accept a byte (high only in IDLE)
//  tx         out  1  serial line; idle/mark = 1
//  tx_busy    out  1  high while a frame is on the line
//  tx_done    out  1  single-cycle pulse after the last stop-bit period
// BEHAVIOUR
//  Reset (s_reset_n=0 at posedge): state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, baud counter and bit index = 0.
//  Reset mid-frame aborts immediately: tx=1 on the next edge, no tx_done pulse, partial byte discarded.
//  Accept: tx_valid & tx_ready at a posedge latches tx_data into the shift register; the next cycle enters START.
//  tx_valid while tx_ready=0 is ignored; the byte is not queued. tx_data changes after accept do not affect the frame.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   START: tx=0 for CLKS_PER_BIT cycles.
//   DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; bit index 0..7, advances on baud-counter rollover.
//   PARITY: exists only with the macro below; one bit period.
//   STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
//  Baud counter: $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1, wraps to 0, and restarts at 0 on every state entry.
//  tx is registered; there is no combinational path from inputs to tx.
//  tx_busy=1 from the first START cycle through the last STOP cycle; tx_ready = (state==IDLE).
//  Latency: accept at edge N -> tx=0 from edge N+1.
//  Frame length F = (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, with P = 1 if parity is enabled, else 0.
//  tx_done=1 for exactly one cycle: the first IDLE cycle after STOP. tx_ready is also 1 in that cycle.
//  Back-to-back: accepting in the tx_done cycle starts the next START with no extra idle gap.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state is inserted after DATA.
//   Parity bit = ^data for PARITY_ODD=0; ~^data for PARITY_ODD=1.
//  UART_TX_PARITY_EN undefined: no PARITY state and no parity logic; PARITY_ODD is ignored; P=0.
// TESTING (sim with CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
//  1. Reset held 3 cycles, tx_valid=0 -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
//  2. Send 0x55, no parity -> tx holds each of 0,1,0,1,0,1,0,1,0,1 for 4 cycles; tx_done pulses 40 cycles after the first tx=0 cycle.
//  3. Two bytes 0x00 then 0xFF, second offered in the tx_done cycle -> second start bit begins the next cycle with no gap; second frame is 0,11111111,1.
//  4. tx_valid pulsed with 0x3C while busy sending 0x81 -> 0x3C is never sent; only one tx_done.
//  5. Reset asserted at cycle 13 of a 0xA5 frame -> tx=1 on the next edge, tx_ready=1, no tx_done; the following 0x12 frame is sent correctly.
//  6. UART_TX_PARITY_EN defined, STOP_BITS=2, send 0xA5 -> parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1; stop high for 8 cycles; F=48.

Source files
------------

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB-first, optional parity, STOP_BITS stop bits.
// Optional parity stage is compiled in with `define UART_TX_PARITY_EN (sense chosen by PARITY_ODD).
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       CLOCK_50,
  input  logic       s_reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       data_reg;
  logic             tx_nxt;
  logic             done_nxt;
  logic             load;
  logic             baud_roll;

`ifdef UART_TX_PARITY_EN
  function automatic logic parity_bit(input logic [7:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction
`endif

  assign baud_roll = (baud_cnt == CNT_MAX);
  assign tx_ready  = (state == IDLE);
  assign tx_busy   = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + 1'b1;
    bit_idx_nxt  = bit_idx;
    done_nxt     = 1'b0;
    load         = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
        if (tx_valid) begin
          state_nxt = START;
          load      = 1'b1;
        end
      end
      START: begin
        if (baud_roll) begin
          state_nxt    = DATA;
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
        end
      end
      DATA: begin
        if (baud_roll) begin
          baud_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt   = PARITY;
`else
            state_nxt   = STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_roll) begin
          state_nxt    = STOP;
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
        end
      end
`endif
      STOP: begin
        // bit_idx doubles as the stop-bit counter
        if (baud_roll) begin
          baud_cnt_nxt = '0;
          if (bit_idx == STOP_LAST) begin
            state_nxt   = IDLE;
            bit_idx_nxt = '0;
            done_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
      end
    endcase

    // line level follows the next state so tx stays aligned with state
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_reg[bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = parity_bit(data_reg);
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!s_reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      tx       <= tx_nxt;
      tx_done  <= done_nxt;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (load) data_reg <= tx_data;
  end

endmodule
